rx_depacketizer: RTL

RX_DEPACKETIZER -- requirements
Module: rx_depacketizer

---
 rtl/rx_pkt_pkg.sv | 24 ++
 rtl/rx_timeout_cnt.sv | 32 +++
 rtl/rx_depacketizer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rx_pkt_pkg.sv
// Shared types and constants for the UART frame depacketizer.
// State encoding, default start-of-frame byte, error cause codes.
package rx_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } rx_state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam logic [1:0] ERR_CHECKSUM = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_FRAMING  = 2'd3;

  // A zero length is never legal; the upper bound is the payload buffer limit.
  function automatic logic len_legal(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/rx_timeout_cnt.sv
// Inter-byte timeout: down-counter reloaded on every byte, expires at terminal count.
// Holds the reload value while disabled so each frame starts a fresh interval.
module rx_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] DEC  = CW'(1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || !en) begin
      cnt_q <= LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DEC;
    end
  end

  // A byte arriving in the terminal cycle masks expiry.
  assign expired = en && !clr && (cnt_q == '0);

endmodule

// File: rtl/rx_depacketizer.sv
// Frame depacketizer: SOF, LEN, LEN payload bytes, CHK (XOR of LEN and payload).
// Payload is streamed to a FIFO one cycle after each byte; result is a one-cycle pulse.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | hunting for SOF, other bytes and rx_err ignored
// ST_LEN     | waiting for length byte
// ST_PAYLOAD | streaming payload, counting down remaining bytes
// ST_CHECK   | waiting for checksum byte
module rx_depacketizer
  import rx_pkt_pkg::*;
#(
  parameter int                    data_width  = 8,
  parameter logic [data_width-1:0] SOF         = SOF_DEFAULT,
  parameter int                    MAX_LEN     = 64,
  parameter int                    TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [data_width-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_err,
  input  logic                  fifo_full,
  output logic [data_width-1:0] d_out,
  output logic                  wr_en,
  output logic                  pkt_done,
  output logic                  pkt_err,
  output logic [1:0]            err_code,
  output logic                  fsm_busy
);

  localparam logic [data_width-1:0] ONE = {{(data_width-1){1'b0}}, 1'b1};

  rx_state_t state, state_nxt;

  logic [data_width-1:0] rem_q, rem_nxt;
  logic [data_width-1:0] xor_q, xor_nxt;
  logic                  ovf_q, ovf_nxt;

  logic [data_width-1:0] d_out_nxt;
  logic                  wr_en_nxt;
  logic                  pkt_done_nxt;
  logic                  pkt_err_nxt;
  logic [1:0]            err_code_nxt;
  logic                  fsm_busy_nxt;

  logic busy_st;
  logic tmo_expired;
  logic abort_err;
  logic abort_tmo;

  assign busy_st   = (state != ST_IDLE);
  assign abort_err = busy_st && rx_err;
  assign abort_tmo = busy_st && !rx_valid && tmo_expired;

  rx_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rx_valid),
    .en     (busy_st),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort_err || abort_tmo) begin
      state_nxt = ST_IDLE;
    end else if (rx_valid) begin
      case (state)
        ST_IDLE:    if (rx_data == SOF) state_nxt = ST_LEN;
        ST_LEN:     state_nxt = len_legal(rx_data, MAX_LEN) ? ST_PAYLOAD : ST_IDLE;
        ST_PAYLOAD: if (rem_q == ONE) state_nxt = ST_CHECK;
        ST_CHECK:   state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    d_out_nxt    = d_out;
    wr_en_nxt    = 1'b0;
    pkt_done_nxt = 1'b0;
    pkt_err_nxt  = 1'b0;
    err_code_nxt = ERR_CHECKSUM;
    rem_nxt      = rem_q;
    xor_nxt      = xor_q;
    ovf_nxt      = ovf_q;
    fsm_busy_nxt = (state_nxt != ST_IDLE);

    if (abort_err) begin
      pkt_err_nxt  = 1'b1;
      err_code_nxt = ERR_FRAMING;
    end else if (abort_tmo) begin
      pkt_err_nxt  = 1'b1;
      err_code_nxt = ERR_TIMEOUT;
    end else if (rx_valid) begin
      case (state)
        ST_LEN: begin
          if (len_legal(rx_data, MAX_LEN)) begin
            rem_nxt = rx_data;
            xor_nxt = rx_data;
            ovf_nxt = 1'b0;
          end else begin
            pkt_err_nxt  = 1'b1;
            err_code_nxt = ERR_FRAMING;
          end
        end
        ST_PAYLOAD: begin
          rem_nxt = rem_q - ONE;
          xor_nxt = xor_q ^ rx_data;
          // A dropped byte poisons the frame but reception runs to the CHK byte.
          if (fifo_full) begin
            ovf_nxt = 1'b1;
          end else begin
            wr_en_nxt = 1'b1;
            d_out_nxt = rx_data;
          end
        end
        ST_CHECK: begin
          if (ovf_q) begin
            pkt_err_nxt  = 1'b1;
            err_code_nxt = ERR_OVERFLOW;
          end else if (xor_q == rx_data) begin
            pkt_done_nxt = 1'b1;
          end else begin
            pkt_err_nxt  = 1'b1;
            err_code_nxt = ERR_CHECKSUM;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out    <= '0;
      wr_en    <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= ERR_CHECKSUM;
      fsm_busy <= 1'b0;
      rem_q    <= '0;
      xor_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      d_out    <= d_out_nxt;
      wr_en    <= wr_en_nxt;
      pkt_done <= pkt_done_nxt;
      pkt_err  <= pkt_err_nxt;
      err_code <= err_code_nxt;
      fsm_busy <= fsm_busy_nxt;
      rem_q    <= rem_nxt;
      xor_q    <= xor_nxt;
      ovf_q    <= ovf_nxt;
    end
  end

endmodule
